// File: rtl/hood_pkg.sv
// Shared definitions for the hood front-end controller and the display stage.
package hood_pkg;

    typedef enum logic [1:0] {
        MODE_STANDBY = 2'd0,
        MODE_SELECT  = 2'd1,
        MODE_RUN     = 2'd2,
        MODE_CLEAN   = 2'd3
    } mode_t;

    localparam logic [1:0] LEVEL_MIN = 2'd1;
    localparam logic [1:0] LEVEL_MAX = 2'd3;

    localparam int unsigned SEC_W   = 10;
    localparam int unsigned LIGHT_W = 7;

    // One bit per button, listed from highest to lowest priority.
    typedef struct packed {
        logic power;
        logic menu;
        logic confirm;
        logic next;
    } btn_t;

    // Fan level step 1->2->3->1.
    function automatic logic [1:0] level_step(input logic [1:0] lvl);
        return (lvl >= LEVEL_MAX) ? LEVEL_MIN : lvl + 2'd1;
    endfunction

    // Status bar with the lowest 2*lvl segments lit.
    function automatic logic [LIGHT_W-1:0] light_bar(input logic [1:0] lvl);
        logic [LIGHT_W:0] ones;
        ones = ((LIGHT_W+1)'(1) << {lvl, 1'b0}) - (LIGHT_W+1)'(1);
        return ones[LIGHT_W-1:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability debouncer and
// single-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DB_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchronise, count stable cycles away from the accepted level, accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYC - 1)) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hood_mode_ctrl.sv
// Hood front-end controller: buttons -> mode FSM, fan level, clean countdown,
// fan PWM and status bar.
// Optional macro HOOD_HOLD_POWER_EN: leaving an active mode needs power held
// for SEC_CYC cycles instead of a single press.
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int unsigned DB_CYC     = 2_000_000,
    parameter int unsigned SEC_CYC    = 100_000_000,
    parameter int unsigned CLEAN_SEC  = 180,
    parameter int unsigned PWM_PERIOD = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_power,
    input  logic               btn_menu,
    input  logic               btn_confirm,
    input  logic               btn_next,
    output logic [1:0]         mode,
    output logic [1:0]         level,
    output logic [SEC_W-1:0]   sec_left,
    output logic               pwm,
    output logic [LIGHT_W-1:0] light
);

    localparam int unsigned TICK_W = (SEC_CYC > 1) ? $clog2(SEC_CYC) : 1;
    localparam int unsigned DUTY_W = $clog2(PWM_PERIOD + 1);
    localparam int unsigned PCNT_W = $clog2(PWM_PERIOD);

    btn_t press_s;
    btn_t db_level;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_power (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_power),
        .level(db_level.power), .press(press_s.power)
    );
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_menu (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_menu),
        .level(db_level.menu), .press(press_s.menu)
    );
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_confirm (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_confirm),
        .level(db_level.confirm), .press(press_s.confirm)
    );
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_next (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_next),
        .level(db_level.next), .press(press_s.next)
    );

    mode_t               state_q, state_d;
    logic [1:0]          level_q, level_d;
    logic [SEC_W-1:0]    sec_q, sec_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [LIGHT_W-1:0]  light_q, light_d;
    logic [PCNT_W-1:0]   pcnt_q;
    logic                pwm_q;
    logic [DUTY_W-1:0]   duty_c;
    logic                power_off_c;
    logic                unused_levels;

`ifdef HOOD_HOLD_POWER_EN
    logic                hold_act_q;
    logic [TICK_W-1:0]   hold_cnt_q;

    // Power-off fires once an armed power hold has lasted SEC_CYC cycles.
    assign power_off_c   = hold_act_q && db_level.power &&
                           (hold_cnt_q == TICK_W'(SEC_CYC - 1));
    assign unused_levels = ^{db_level.menu, db_level.confirm, db_level.next};

    // Arm on a power press in an active mode; drop when the button is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_act_q <= 1'b0;
            hold_cnt_q <= '0;
        end else if (!db_level.power || state_q == MODE_STANDBY) begin
            hold_act_q <= 1'b0;
            hold_cnt_q <= '0;
        end else if (press_s.power) begin
            hold_act_q <= 1'b1;
            hold_cnt_q <= '0;
        end else if (hold_act_q && !power_off_c) begin
            hold_cnt_q <= hold_cnt_q + TICK_W'(1);
        end
    end
`else
    assign power_off_c   = press_s.power;
    assign unused_levels = ^db_level;
`endif

    // State, level, countdown and status-bar registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MODE_STANDBY;
            level_q <= LEVEL_MIN;
            sec_q   <= '0;
            tick_q  <= '0;
            light_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            light_q <= light_d;
        end
    end

    // Next-state logic; presses are taken in priority power > menu > confirm > next.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        sec_d   = sec_q;
        tick_d  = tick_q;
        case (state_q)
            MODE_STANDBY: begin
                if (press_s.power) state_d = MODE_SELECT;
            end
            MODE_SELECT: begin
                if (power_off_c) begin
                    state_d = MODE_STANDBY;
                end else if (press_s.menu) begin
                    state_d = MODE_CLEAN;
                    sec_d   = SEC_W'(CLEAN_SEC);
                    tick_d  = '0;
                end else if (press_s.confirm) begin
                    state_d = MODE_RUN;
                end else if (press_s.next) begin
                    level_d = level_step(level_q);
                end
            end
            MODE_RUN: begin
                if (power_off_c) begin
                    state_d = MODE_STANDBY;
                end else if (press_s.menu) begin
                    state_d = MODE_SELECT;
                end else if (press_s.next) begin
                    level_d = level_step(level_q);
                end
            end
            MODE_CLEAN: begin
                if (power_off_c) begin
                    state_d = MODE_STANDBY;
                    sec_d   = '0;
                end else if (press_s.menu) begin
                    state_d = MODE_SELECT;
                    sec_d   = '0;
                end else if (tick_q == TICK_W'(SEC_CYC - 1)) begin
                    tick_d = '0;
                    sec_d  = (sec_q == '0) ? '0 : sec_q - SEC_W'(1);
                    if (sec_q <= SEC_W'(1)) state_d = MODE_SELECT;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = MODE_STANDBY;
        endcase
        light_d = (state_d == MODE_RUN) ? light_bar(level_d) : '0;
    end

    // Fan duty from the current mode and level.
    always_comb begin
        duty_c = '0;
        case (state_q)
            MODE_RUN:   duty_c = DUTY_W'(level_q) * DUTY_W'(PWM_PERIOD / 4);
            MODE_CLEAN: duty_c = DUTY_W'(PWM_PERIOD);
            default:    duty_c = '0;
        endcase
    end

    // Free-running PWM counter and registered compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            pcnt_q <= (pcnt_q == PCNT_W'(PWM_PERIOD - 1)) ? '0 : pcnt_q + PCNT_W'(1);
            pwm_q  <= (DUTY_W'(pcnt_q) < duty_c);
        end
    end

    assign mode     = state_q;
    assign level    = level_q;
    assign sec_left = sec_q;
    assign light    = light_q;
    assign pwm      = pwm_q;

endmodule
